aq_pmp_chk_arb: RTL and testbench



---
 rtl/aq_pmp_chk_arb_if.sv | 56 +++++
 rtl/aq_pmp_chk_arb.sv | 120 ++++++++++++
 tb/tb_aq_pmp_chk_arb.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aq_pmp_chk_arb_if.sv
// Request, grant, response and PMP-check signals of the shared PMP check port.
// The arbiter uses the slave modport; requesters and the PMP checker form the master side.
interface aq_pmp_chk_arb_if;
    logic        ifu_arb_req;
    logic        lsu_arb_req;
    logic        ptw_arb_req;
    logic [27:0] ifu_arb_pa;
    logic [27:0] lsu_arb_pa;
    logic [27:0] ptw_arb_pa;
    logic [1:0]  ifu_arb_priv_mode;
    logic [1:0]  lsu_arb_priv_mode;
    logic [1:0]  ptw_arb_priv_mode;
    logic        ifu_arb_chk1;
    logic        lsu_arb_chk1;
    logic        ptw_arb_chk1;
    logic        arb_ifu_gnt;
    logic        arb_lsu_gnt;
    logic        arb_ptw_gnt;
    logic        arb_ifu_resp_vld;
    logic        arb_lsu_resp_vld;
    logic        arb_ptw_resp_vld;
    logic [3:0]  arb_resp_flg;
    logic        arb_resp_napot_cross;
    logic [27:0] arb_pmp_pa;
    logic [1:0]  arb_pmp_priv_mode;
    logic        arb_pmp_chk1;
    logic [3:0]  pmp_arb_flg;
    logic        pmp_arb_napot_cross;
    logic        cp0_pmp_wreg;
    logic [11:0] cp0_pmp_addr;
    logic        arb_busy;

    modport slave (
        input  ifu_arb_req, lsu_arb_req, ptw_arb_req,
        input  ifu_arb_pa, lsu_arb_pa, ptw_arb_pa,
        input  ifu_arb_priv_mode, lsu_arb_priv_mode, ptw_arb_priv_mode,
        input  ifu_arb_chk1, lsu_arb_chk1, ptw_arb_chk1,
        input  pmp_arb_flg, pmp_arb_napot_cross, cp0_pmp_wreg, cp0_pmp_addr,
        output arb_ifu_gnt, arb_lsu_gnt, arb_ptw_gnt,
        output arb_ifu_resp_vld, arb_lsu_resp_vld, arb_ptw_resp_vld,
        output arb_resp_flg, arb_resp_napot_cross,
        output arb_pmp_pa, arb_pmp_priv_mode, arb_pmp_chk1, arb_busy
    );

    modport master (
        output ifu_arb_req, lsu_arb_req, ptw_arb_req,
        output ifu_arb_pa, lsu_arb_pa, ptw_arb_pa,
        output ifu_arb_priv_mode, lsu_arb_priv_mode, ptw_arb_priv_mode,
        output ifu_arb_chk1, lsu_arb_chk1, ptw_arb_chk1,
        output pmp_arb_flg, pmp_arb_napot_cross, cp0_pmp_wreg, cp0_pmp_addr,
        input  arb_ifu_gnt, arb_lsu_gnt, arb_ptw_gnt,
        input  arb_ifu_resp_vld, arb_lsu_resp_vld, arb_ptw_resp_vld,
        input  arb_resp_flg, arb_resp_napot_cross,
        input  arb_pmp_pa, arb_pmp_priv_mode, arb_pmp_chk1, arb_busy
    );
endinterface

// File: rtl/aq_pmp_chk_arb.sv
// Arbiter for the shared PMP check port: ptw-priority with starvation relief,
// ifu/lsu round robin, and a fence around PMP CSR writes.
module aq_pmp_chk_arb #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            forever_cpuclk,
    input  logic            cpurst,
    aq_pmp_chk_arb_if.slave bus
);
    localparam int IFU = 0;
    localparam int LSU = 1;
    localparam int PTW = 2;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic {ST_ARB = 1'b0, ST_FENCE = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic        rr_ptr_reg, rr_ptr_next;
    logic [3:0]  starve_cnt_reg, starve_cnt_next;
    logic [2:0]  resp_vld_reg;
    logic [3:0]  resp_flg_reg;
    logic        resp_napot_reg;
    logic [2:0]  req;
    logic [2:0]  gnt;
    logic [2:0]  resp_vld;
    logic        pmp_wr;
    logic        other_req;
    logic        force_slot;
    logic        rr_pick_lsu;

    assign req = {bus.ptw_arb_req, bus.lsu_arb_req, bus.ifu_arb_req};
    assign other_req = req[IFU] | req[LSU];
    assign pmp_wr = bus.cp0_pmp_wreg &&
                    (bus.cp0_pmp_addr == 12'h3A0 || bus.cp0_pmp_addr == 12'h3A2 ||
                     bus.cp0_pmp_addr[11:4] == 8'h3B);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ARB:   if (pmp_wr) state_next = ST_FENCE;
            ST_FENCE: state_next = pmp_wr ? ST_FENCE : ST_ARB;
            default:  state_next = ST_ARB;
        endcase
    end

    // ptw wins unless ifu/lsu have been passed over STARVE_MAX times in a row
    always_comb begin
        gnt         = 3'b000;
        force_slot  = (starve_cnt_reg == STARVE_LIM) && other_req;
        rr_pick_lsu = req[LSU] && (rr_ptr_reg || !req[IFU]);
        if (state_reg == ST_ARB && !pmp_wr && !cpurst) begin
            if (req[PTW] && !force_slot) gnt[PTW] = 1'b1;
            else if (rr_pick_lsu)        gnt[LSU] = 1'b1;
            else if (req[IFU])           gnt[IFU] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_next     = rr_ptr_reg;
        starve_cnt_next = starve_cnt_reg;
        if (gnt[IFU]) rr_ptr_next = 1'b1;
        if (gnt[LSU]) rr_ptr_next = 1'b0;
        if (gnt[IFU] || gnt[LSU]) begin
            starve_cnt_next = 4'd0;
        end else if (gnt[PTW]) begin
            if (!other_req)                        starve_cnt_next = 4'd0;
            else if (starve_cnt_reg != STARVE_LIM) starve_cnt_next = starve_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_reg      <= ST_ARB;
            rr_ptr_reg     <= 1'b0;
            starve_cnt_reg <= 4'd0;
            resp_vld_reg   <= 3'b000;
            resp_flg_reg   <= 4'd0;
            resp_napot_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            starve_cnt_reg <= starve_cnt_next;
            resp_vld_reg   <= gnt;
            if (|gnt) begin
                resp_flg_reg   <= bus.pmp_arb_flg;
                resp_napot_reg <= bus.pmp_arb_napot_cross;
            end
        end
    end

    // A response in flight is suppressed the moment reset is asserted
    for (genvar gi = 0; gi < 3; gi++) begin : g_resp
        assign resp_vld[gi] = resp_vld_reg[gi] & ~cpurst;
    end

    always_comb begin
        bus.arb_pmp_pa        = bus.ptw_arb_pa;
        bus.arb_pmp_priv_mode = bus.ptw_arb_priv_mode;
        bus.arb_pmp_chk1      = bus.ptw_arb_chk1;
        if (gnt[IFU]) begin
            bus.arb_pmp_pa        = bus.ifu_arb_pa;
            bus.arb_pmp_priv_mode = bus.ifu_arb_priv_mode;
            bus.arb_pmp_chk1      = bus.ifu_arb_chk1;
        end else if (gnt[LSU]) begin
            bus.arb_pmp_pa        = bus.lsu_arb_pa;
            bus.arb_pmp_priv_mode = bus.lsu_arb_priv_mode;
            bus.arb_pmp_chk1      = bus.lsu_arb_chk1;
        end
    end

    assign bus.arb_ifu_gnt          = gnt[IFU];
    assign bus.arb_lsu_gnt          = gnt[LSU];
    assign bus.arb_ptw_gnt          = gnt[PTW];
    assign bus.arb_ifu_resp_vld     = resp_vld[IFU];
    assign bus.arb_lsu_resp_vld     = resp_vld[LSU];
    assign bus.arb_ptw_resp_vld     = resp_vld[PTW];
    assign bus.arb_resp_flg         = resp_flg_reg;
    assign bus.arb_resp_napot_cross = resp_napot_reg;
    assign bus.arb_busy             = !cpurst && ((|gnt) || state_reg == ST_FENCE || pmp_wr);
endmodule

// File: tb/tb_aq_pmp_chk_arb.sv
// Directed test-plan scenarios plus randomized traffic, all checked every cycle
// against a cycle-count based model of the arbitration rules.
module tb_aq_pmp_chk_arb;
    localparam int SMAX = 4;
    localparam int IFU = 0, LSU = 1, PTW = 2, NONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aq_pmp_chk_arb_if bus();
    aq_pmp_chk_arb #(.STARVE_MAX(SMAX)) dut (
        .forever_cpuclk(clk),
        .cpurst(rst),
        .bus(bus)
    );

    logic        req [3];
    logic [27:0] pa  [3];
    logic [1:0]  pv  [3];
    logic        c1  [3];
    logic [3:0]  pflg;
    logic        pnx;
    logic        wreg;
    logic [11:0] waddr;

    assign bus.ifu_arb_req = req[IFU];
    assign bus.lsu_arb_req = req[LSU];
    assign bus.ptw_arb_req = req[PTW];
    assign bus.ifu_arb_pa = pa[IFU];
    assign bus.lsu_arb_pa = pa[LSU];
    assign bus.ptw_arb_pa = pa[PTW];
    assign bus.ifu_arb_priv_mode = pv[IFU];
    assign bus.lsu_arb_priv_mode = pv[LSU];
    assign bus.ptw_arb_priv_mode = pv[PTW];
    assign bus.ifu_arb_chk1 = c1[IFU];
    assign bus.lsu_arb_chk1 = c1[LSU];
    assign bus.ptw_arb_chk1 = c1[PTW];
    assign bus.pmp_arb_flg = pflg;
    assign bus.pmp_arb_napot_cross = pnx;
    assign bus.cp0_pmp_wreg = wreg;
    assign bus.cp0_pmp_addr = waddr;

    wire [2:0] gnt_v = {bus.arb_ptw_gnt, bus.arb_lsu_gnt, bus.arb_ifu_gnt};
    wire [2:0] rv_v  = {bus.arb_ptw_resp_vld, bus.arb_lsu_resp_vld, bus.arb_ifu_resp_vld};

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] onehot(input int w);
        logic [2:0] v;
        v = 3'b000;
        if (w != NONE) v[w] = 1'b1;
        return v;
    endfunction

    // Model state: who was last served among ifu/lsu, how many ptw wins in a row
    // passed over a waiting ifu/lsu, and the cycle number of the most recent PMP write.
    int         m_cyc = 0;
    int         m_last_wr = -10;
    int         m_last_rr = LSU;
    int         m_streak = 0;
    int         m_pend = NONE;
    logic [3:0] m_flg = 4'd0;
    logic       m_nx = 1'b0;
    int         exp_win = NONE;

    always @(negedge clk) begin
        int  w;
        int  e;
        bit  wr;
        bit  fence;
        bit  oth;
        if (rst) begin
            check("rst_gnt", 32'(gnt_v), 32'd0);
            check("rst_resp_vld", 32'(rv_v), 32'd0);
            check("rst_busy", 32'(bus.arb_busy), 32'd0);
            m_last_rr = LSU;
            m_streak  = 0;
            m_last_wr = m_cyc - 10;
            m_pend    = NONE;
            m_flg     = 4'd0;
            m_nx      = 1'b0;
            exp_win   = NONE;
        end else begin
            wr    = wreg && (waddr == 12'h3A0 || waddr == 12'h3A2 ||
                             (waddr >= 12'h3B0 && waddr <= 12'h3BF));
            fence = (m_cyc - m_last_wr) == 1;
            oth   = req[IFU] || req[LSU];
            w = NONE;
            if (!wr && !fence) begin
                if (req[PTW] && !(m_streak >= SMAX && oth)) w = PTW;
                else if (req[IFU] && req[LSU])             w = (m_last_rr == IFU) ? LSU : IFU;
                else if (req[IFU])                          w = IFU;
                else if (req[LSU])                          w = LSU;
            end
            e = (w == NONE) ? PTW : w;
            check("gnt", 32'(gnt_v), 32'(onehot(w)));
            check("resp_vld", 32'(rv_v), 32'(onehot(m_pend)));
            check("resp_flg", 32'(bus.arb_resp_flg), 32'(m_flg));
            check("resp_napot", 32'(bus.arb_resp_napot_cross), 32'(m_nx));
            check("busy", 32'(bus.arb_busy), 32'((w != NONE) || fence || wr));
            check("pmp_pa", 32'(bus.arb_pmp_pa), 32'(pa[e]));
            check("pmp_priv", 32'(bus.arb_pmp_priv_mode), 32'(pv[e]));
            check("pmp_chk1", 32'(bus.arb_pmp_chk1), 32'(c1[e]));
            m_pend = w;
            if (w != NONE) begin
                m_flg = pflg;
                m_nx  = pnx;
            end
            if (w == PTW) begin
                m_streak = oth ? ((m_streak + 1 > SMAX) ? SMAX : m_streak + 1) : 0;
            end else if (w != NONE) begin
                m_streak  = 0;
                m_last_rr = w;
            end
            if (wr) m_last_wr = m_cyc;
            exp_win = w;
        end
        m_cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int r = 0; r < 3; r++) begin
            req[r] = 1'b0;
            pa[r]  = 28'h0;
            pv[r]  = 2'd0;
            c1[r]  = 1'b0;
        end
        wreg  = 1'b0;
        waddr = 12'h000;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [2:0]  seq_rr   [5]  = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001};
    logic [2:0]  seq_stv  [10] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001,
                                   3'b100, 3'b100, 3'b100, 3'b100, 3'b010};
    logic [2:0]  seq_fen  [4]  = '{3'b000, 3'b000, 3'b000, 3'b010};
    logic [11:0] addr_tab [8]  = '{12'h3A0, 12'h3A2, 12'h3B0, 12'h3B7,
                                   12'h3BF, 12'h3A1, 12'h300, 12'h3C0};

    initial begin
        idle();
        pflg = 4'd0;
        pnx  = 1'b0;
        rst  = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // ifu alone: same-cycle grant, flags returned next cycle
        req[IFU] = 1'b1; pa[IFU] = 28'h0001234; pv[IFU] = 2'd0;
        pflg = 4'b0101; pnx = 1'b1;
        @(negedge clk);
        check("d_ifu_gnt", 32'(gnt_v), 32'(3'b001));
        check("d_ifu_pa", 32'(bus.arb_pmp_pa), 32'h0001234);
        step();
        req[IFU] = 1'b0; pflg = 4'b1010; pnx = 1'b0;
        @(negedge clk);
        check("d_ifu_resp", 32'(rv_v), 32'(3'b001));
        check("d_ifu_flg", 32'(bus.arb_resp_flg), 32'(4'b0101));
        check("d_ifu_napot", 32'(bus.arb_resp_napot_cross), 32'd1);
        step();
        check("d_flg_hold", 32'(bus.arb_resp_flg), 32'(4'b0101));

        // ifu+lsu alternate; fifth grant back to ifu
        do_reset();
        req[IFU] = 1'b1; req[LSU] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("d_rr_gnt", 32'(gnt_v), 32'(seq_rr[i]));
            step();
        end

        // all three held: starvation relief every STARVE_MAX ptw grants
        do_reset();
        req[IFU] = 1'b1; req[LSU] = 1'b1; req[PTW] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("d_starve_gnt", 32'(gnt_v), 32'(seq_stv[i]));
            step();
        end

        // PMP write fences two cycles; non-PMP CSR does not
        do_reset();
        req[LSU] = 1'b1; wreg = 1'b1; waddr = 12'h3B2;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("d_fence_gnt", 32'(gnt_v), 32'(seq_fen[i]));
            check("d_fence_busy", 32'(bus.arb_busy), 32'd1);
            step();
            wreg = 1'b0;
        end
        req[LSU] = 1'b0;
        @(negedge clk);
        check("d_fence_resp", 32'(rv_v), 32'(3'b010));
        step();
        req[LSU] = 1'b1; wreg = 1'b1; waddr = 12'h300;
        @(negedge clk);
        check("d_nonpmp_gnt", 32'(gnt_v), 32'(3'b010));
        step();
        req[LSU] = 1'b0; wreg = 1'b0;
        step();

        // back-to-back writes re-enter FENCE
        req[LSU] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wreg = (i < 2); waddr = (i == 0) ? 12'h3A0 : 12'h3BF;
            @(negedge clk);
            check("d_refence_gnt", 32'(gnt_v), 32'(seq_fen[i]));
            step();
        end
        idle();
        step();

        // reset with a ptw response pending drops it; rr restarts at ifu
        req[PTW] = 1'b1;
        @(negedge clk);
        check("d_ptw_gnt", 32'(gnt_v), 32'(3'b100));
        step();
        req[PTW] = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("d_rst_drop", 32'(rv_v), 32'd0);
        step();
        step();
        rst = 1'b0; req[IFU] = 1'b1; req[LSU] = 1'b1;
        @(negedge clk);
        check("d_rst_rr", 32'(gnt_v), 32'(3'b001));
        step();
        idle();
        step();

        // randomized traffic honouring the hold-until-grant rule, with withdrawals
        for (int c = 0; c < 4000; c++) begin
            rst = (!rst && $urandom_range(0, 199) == 0);
            for (int r = 0; r < 3; r++) begin
                if (req[r] && exp_win != r) begin
                    if ($urandom_range(0, 19) == 0) req[r] = 1'b0;
                end else begin
                    req[r] = ($urandom_range(0, 99) < ((r == PTW) ? 80 : 55));
                    pa[r]  = 28'($urandom);
                    pv[r]  = 2'($urandom);
                    c1[r]  = 1'($urandom);
                end
            end
            wreg  = ($urandom_range(0, 9) == 0);
            waddr = addr_tab[$urandom_range(0, 7)];
            pflg  = 4'($urandom);
            pnx   = 1'($urandom);
            step();
        end
        rst = 1'b0;
        idle();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
